ica_iter_controller: RTL and testbench

ICA_ITER_CONTROLLER -- requirements
Module: ica_iter_controller

---
 rtl/ica_iter_controller.sv | 126 ++++++++++++
 tb/tb_ica_iter_controller.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ica_iter_controller.sv
// Iteration sequencer for the ICA engine: launches the fast controller, normalises,
// checks convergence, and guards every wait phase with a watchdog.
module ica_iter_controller #(
   parameter logic [7:0]  MAX_ITER = 8'd100,
   parameter logic [15:0] EPS      = 16'd64,
   parameter logic [8:0]  WDOG     = 9'd300
) (
   input  logic        clk_ica,
   input  logic        go_ica,
   input  logic        start,
   input  logic        fast_busy,
   input  logic [15:0] delta,
   input  logic        delta_valid,
   output logic        go_fast,
   output logic        en_norm,
   output logic        en_conv,
   output logic [7:0]  iter_cnt,
   output logic        busy,
   output logic        done,
   output logic        converged,
   output logic        timeout_err
);

   typedef enum logic [2:0] {
      IDLE, LAUNCH, WAIT_BUSY, RUN, NORM, CHECK, DONE, ERROR
   } state_t;

   state_t     state, state_nxt;
   logic [8:0] wdog;
   logic       wdog_hit;
   logic       run_clr;
   logic       iter_inc;
   logic       conv_set;

   // Limit is hit on the WDOG-th cycle spent in a guarded state.
   assign wdog_hit = (wdog == WDOG - 9'd1);

   always_comb begin
      state_nxt = state;
      run_clr   = 1'b0;
      iter_inc  = 1'b0;
      conv_set  = 1'b0;
      case (state)
         IDLE, DONE: begin
            if (start) begin
               state_nxt = LAUNCH;
               run_clr   = 1'b1;
            end
         end
         LAUNCH:    state_nxt = WAIT_BUSY;
         WAIT_BUSY: begin
            if (fast_busy)     state_nxt = RUN;
            else if (wdog_hit) state_nxt = ERROR;
         end
         RUN: begin
            if (!fast_busy)    state_nxt = NORM;
            else if (wdog_hit) state_nxt = ERROR;
         end
         NORM:      state_nxt = CHECK;
         CHECK: begin
            if (delta_valid) begin
               iter_inc = 1'b1;
               if (delta <= EPS) begin
                  state_nxt = DONE;
                  conv_set  = 1'b1;
               end else if (iter_cnt + 8'd1 == MAX_ITER) begin
                  state_nxt = DONE;
               end else begin
                  state_nxt = LAUNCH;
               end
            end else if (wdog_hit) begin
               state_nxt = ERROR;
            end
         end
         ERROR:     state_nxt = ERROR;
         default:   state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk_ica or negedge go_ica) begin
      if (!go_ica) state <= IDLE;
      else         state <= state_nxt;
   end

   always_ff @(posedge clk_ica or negedge go_ica) begin
      if (!go_ica) begin
         iter_cnt  <= '0;
         converged <= 1'b0;
         wdog      <= '0;
      end else begin
         if (run_clr) begin
            iter_cnt  <= '0;
            converged <= 1'b0;
         end else begin
            if (iter_inc) iter_cnt  <= iter_cnt + 8'd1;
            if (conv_set) converged <= 1'b1;
         end
         if (run_clr)
            wdog <= '0;
         else if (state_nxt != state && state_nxt inside {WAIT_BUSY, RUN, CHECK})
            wdog <= '0;
         else if (state inside {WAIT_BUSY, RUN, CHECK})
            wdog <= wdog + 9'd1;
      end
   end

   // Outputs are flops loaded from the next state, so they track the state register exactly.
   always_ff @(posedge clk_ica or negedge go_ica) begin
      if (!go_ica) begin
         go_fast     <= 1'b0;
         en_norm     <= 1'b0;
         en_conv     <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
         timeout_err <= 1'b0;
      end else begin
         go_fast     <= state_nxt inside {LAUNCH, WAIT_BUSY, RUN};
         en_norm     <= (state_nxt == NORM);
         en_conv     <= (state_nxt == CHECK);
         busy        <= !(state_nxt inside {IDLE, DONE, ERROR});
         done        <= (state_nxt == DONE);
         timeout_err <= (state_nxt == ERROR);
      end
   end

endmodule

// File: tb/tb_ica_iter_controller.sv
// Directed bench for ica_iter_controller with a fast-controller model, a delta responder
// and a run scoreboard.
module tb_ica_iter_controller;

   localparam int BUSY_LEN = 132;

   logic        clk = 1'b0;
   logic        go_ica, start;
   logic        fast_busy = 1'b0;
   logic        dv_auto = 1'b0;
   logic        dv_man;
   logic        delta_valid;
   logic [15:0] delta = '0;
   logic        go_fast, en_norm, en_conv, busy, done, converged, timeout_err;
   logic [7:0]  iter_cnt;

   always #5 clk = ~clk;
   assign delta_valid = dv_auto | dv_man;

   ica_iter_controller #(.MAX_ITER(8'd3), .EPS(16'd64), .WDOG(9'd300)) dut (
      .clk_ica(clk), .go_ica(go_ica), .start(start), .fast_busy(fast_busy),
      .delta(delta), .delta_valid(delta_valid), .go_fast(go_fast), .en_norm(en_norm),
      .en_conv(en_conv), .iter_cnt(iter_cnt), .busy(busy), .done(done),
      .converged(converged), .timeout_err(timeout_err)
   );

   typedef struct {
      logic       done;
      logic       conv;
      logic [7:0] iter;
      int         wins;
      int         norms;
   } exp_t;

   exp_t        sb[$];
   logic [15:0] delta_tab [4];
   logic        fast_en = 1'b1;
   int          checks = 0, errors = 0;
   int          fcnt = 0, ccnt = 0, win_cnt = 0, norm_cnt = 0, chk_cnt = 0;
   logic        go_fast_d = 1'b0;
   int          win_base = 0, norm_base = 0, chk_base = 0;

   // Fast-controller model, delta responder and pulse monitor, all on the inactive edge.
   always @(negedge clk) begin
      if (go_fast && !go_fast_d) win_cnt++;
      go_fast_d = go_fast;
      if (en_norm) norm_cnt++;
      if (!go_fast) begin
         fcnt      = 0;
         fast_busy = 1'b0;
      end else if (fast_en) begin
         fcnt++;
         fast_busy = (fcnt >= 2) && (fcnt < 2 + BUSY_LEN);
      end else begin
         fast_busy = 1'b0;
      end
      if (en_conv) begin
         if (ccnt == 0) begin
            delta = delta_tab[(chk_cnt - chk_base) & 3];
            chk_cnt++;
         end
         ccnt++;
         dv_auto = (ccnt == 2);
      end else begin
         ccnt    = 0;
         dv_auto = 1'b0;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      checks++;
      assert (obs === exp_v) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
      end
   endtask

   task automatic expect_run(input logic d, input logic c, input logic [7:0] it,
                             input int w, input int n);
      exp_t e;
      e.done = d; e.conv = c; e.iter = it; e.wins = w; e.norms = n;
      sb.push_back(e);
   endtask

   task automatic start_pulse();
      win_base  = win_cnt;
      norm_base = norm_cnt;
      chk_base  = chk_cnt;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic wait_end(input string tag);
      bit seen = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         @(posedge clk); #1;
         if (done || timeout_err) begin
            seen = 1'b1;
            break;
         end
      end
      chk(tag, 32'(seen), 32'd1);
   endtask

   task automatic wait_fast_busy(input string tag);
      bit seen = 1'b0;
      for (int i = 0; i < 50; i++) begin
         @(posedge clk); #1;
         if (fast_busy) begin
            seen = 1'b1;
            break;
         end
      end
      chk(tag, 32'(seen), 32'd1);
   endtask

   task automatic finish_run(input string tag);
      exp_t e;
      if (sb.size() == 0) begin
         chk({tag, "_sb"}, 32'd0, 32'd1);
         return;
      end
      e = sb.pop_front();
      chk({tag, "_done"},  32'(done),      32'(e.done));
      chk({tag, "_conv"},  32'(converged), 32'(e.conv));
      chk({tag, "_iter"},  32'(iter_cnt),  32'(e.iter));
      chk({tag, "_wins"},  32'(win_cnt - win_base),   32'(e.wins));
      chk({tag, "_norms"}, 32'(norm_cnt - norm_base), 32'(e.norms));
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_go_fast"},   32'(go_fast),     32'd0);
      chk({tag, "_en_norm"},   32'(en_norm),     32'd0);
      chk({tag, "_en_conv"},   32'(en_conv),     32'd0);
      chk({tag, "_iter"},      32'(iter_cnt),    32'd0);
      chk({tag, "_busy"},      32'(busy),        32'd0);
      chk({tag, "_done"},      32'(done),        32'd0);
      chk({tag, "_converged"}, 32'(converged),   32'd0);
      chk({tag, "_timeout"},   32'(timeout_err), 32'd0);
   endtask

   initial begin
      bit seen;
      go_ica = 1'b0;
      start  = 1'b0;
      dv_man = 1'b0;
      for (int i = 0; i < 4; i++) delta_tab[i] = '0;
      repeat (3) @(posedge clk);
      #1;
      chk_all_zero("reset");
      go_ica = 1'b1;
      @(posedge clk); #1;

      // single iteration, converges
      delta_tab[0] = 16'd10;
      expect_run(1'b1, 1'b1, 8'd1, 1, 1);
      start_pulse();
      chk("launch_go_fast", 32'(go_fast), 32'd1);
      chk("launch_busy",    32'(busy),    32'd1);
      wait_end("run1_end");
      finish_run("run1");

      // never converges: stops at MAX_ITER
      for (int i = 0; i < 4; i++) delta_tab[i] = 16'd500;
      expect_run(1'b1, 1'b0, 8'd3, 3, 3);
      start_pulse();
      wait_end("maxit_end");
      finish_run("maxit");

      // delta == EPS on the last iteration: convergence wins
      delta_tab[0] = 16'd500; delta_tab[1] = 16'd500; delta_tab[2] = 16'd64;
      expect_run(1'b1, 1'b1, 8'd3, 3, 3);
      start_pulse();
      wait_end("prio_end");
      finish_run("prio");

      // EPS+1 continues, EPS converges
      delta_tab[0] = 16'd65; delta_tab[1] = 16'd64;
      expect_run(1'b1, 1'b1, 8'd2, 2, 2);
      start_pulse();
      wait_end("eps_end");
      finish_run("eps");

      // start / delta_valid noise in RUN and NORM
      delta_tab[0] = 16'd10;
      expect_run(1'b1, 1'b1, 8'd1, 1, 1);
      start_pulse();
      wait_fast_busy("ign_fast_busy");
      repeat (3) @(posedge clk);
      #1;
      for (int i = 0; i < 6; i++) begin
         start  = (i % 2 == 0);
         dv_man = (i % 2 == 0);
         @(posedge clk); #1;
         chk("ign_run_iter",    32'(iter_cnt), 32'd0);
         chk("ign_run_go_fast", 32'(go_fast),  32'd1);
      end
      start  = 1'b0;
      dv_man = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 400; i++) begin
         @(posedge clk); #1;
         if (en_norm) begin
            seen = 1'b1;
            break;
         end
      end
      chk("ign_norm_seen", 32'(seen), 32'd1);
      start  = 1'b1;
      dv_man = 1'b1;
      @(posedge clk); #1;
      chk("ign_norm_en_conv", 32'(en_conv),  32'd1);
      chk("ign_norm_iter",    32'(iter_cnt), 32'd0);
      chk("ign_norm_go_fast", 32'(go_fast),  32'd0);
      start  = 1'b0;
      dv_man = 1'b0;
      wait_end("ign_end");
      finish_run("ign");

      // restart from DONE clears run state
      expect_run(1'b1, 1'b1, 8'd1, 1, 1);
      start_pulse();
      chk("restart_iter",    32'(iter_cnt),  32'd0);
      chk("restart_conv",    32'(converged), 32'd0);
      chk("restart_done",    32'(done),      32'd0);
      chk("restart_go_fast", 32'(go_fast),   32'd1);
      wait_end("restart_end");
      finish_run("restart");

      // watchdog in WAIT_BUSY
      fast_en = 1'b0;
      start_pulse();
      @(posedge clk); #1;
      chk("wd_wait_go_fast", 32'(go_fast), 32'd1);
      repeat (299) @(posedge clk);
      #1;
      chk("wd_299_timeout", 32'(timeout_err), 32'd0);
      chk("wd_299_go_fast", 32'(go_fast),     32'd1);
      @(posedge clk); #1;
      chk("wd_300_timeout", 32'(timeout_err), 32'd1);
      chk("wd_300_go_fast", 32'(go_fast),     32'd0);
      chk("wd_300_busy",    32'(busy),        32'd0);
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("wd_sticky_timeout", 32'(timeout_err), 32'd1);
      chk("wd_sticky_go_fast", 32'(go_fast),     32'd0);
      go_ica = 1'b0;
      #2;
      go_ica = 1'b1;
      @(posedge clk); #1;
      chk("wd_clr_timeout", 32'(timeout_err), 32'd0);
      chk("wd_clr_busy",    32'(busy),        32'd0);
      fast_en = 1'b1;

      // asynchronous reset mid-RUN
      delta_tab[0] = 16'd10;
      start_pulse();
      wait_fast_busy("arst_fast_busy");
      repeat (5) @(posedge clk);
      #1;
      chk("arst_pre_busy", 32'(busy), 32'd1);
      #2;
      go_ica = 1'b0;
      #1;
      chk_all_zero("arst");
      #3;
      go_ica = 1'b1;
      @(posedge clk); #1;
      chk("arst_post_busy",    32'(busy),    32'd0);
      chk("arst_post_go_fast", 32'(go_fast), 32'd0);
      expect_run(1'b1, 1'b1, 8'd1, 1, 1);
      start_pulse();
      wait_end("post_arst_end");
      finish_run("post_arst");

      chk("sb_empty", 32'(sb.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
